// File: rtl/mux_rr_stream.sv
// Registered CHANNELS:1 stream merger with fixed-select
// and round-robin channel arbitration.
module mux_rr_stream #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 16,
  parameter int SEL_BITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_BITS-1:0]       select,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_BITS-1:0]       out_channel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               xfer_count
);

  logic [WIDTH-1:0]    chan [CHANNELS];
  logic [SEL_BITS-1:0] last_grant;
  logic [SEL_BITS-1:0] gnt;
  logic [WIDTH-1:0]    gnt_data;
  logic                gnt_ok;
  logic                can_load;
  logic                xfer;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign chan[g] = in_data[g*WIDTH +: WIDTH];
  end

  assign can_load = !out_valid || out_ready;
  assign xfer     = gnt_ok && can_load && !reset;

  // Round-robin: scan above last_grant first, then wrap to 0..last_grant.
  always_comb begin
    gnt_ok   = 1'b0;
    gnt      = '0;
    gnt_data = '0;
    if (!mode) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (select == SEL_BITS'(k) && in_valid[k]) begin
          gnt_ok   = 1'b1;
          gnt      = SEL_BITS'(k);
          gnt_data = chan[k];
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (!gnt_ok && k > int'(last_grant) && in_valid[k]) begin
          gnt_ok   = 1'b1;
          gnt      = SEL_BITS'(k);
          gnt_data = chan[k];
        end
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (!gnt_ok && k <= int'(last_grant) && in_valid[k]) begin
          gnt_ok   = 1'b1;
          gnt      = SEL_BITS'(k);
          gnt_data = chan[k];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      in_ready[k] = xfer && (gnt == SEL_BITS'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data    <= '0;
      out_channel <= '0;
      out_valid   <= 1'b0;
      xfer_count  <= '0;
      last_grant  <= SEL_BITS'(CHANNELS - 1);
    end else if (xfer) begin
      out_data    <= gnt_data;
      out_channel <= gnt;
      out_valid   <= 1'b1;
      last_grant  <= gnt;
      xfer_count  <= xfer_count + 16'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Randomized and directed checks of mux_rr_stream
// against a queue-free behavioural reference model.
module tb_mux_rr_stream;

  localparam int W = 8;
  localparam int N = 16;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           mode;
  logic [S-1:0]   select;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_channel;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    xfer_count;

  mux_rr_stream #(.WIDTH(W), .CHANNELS(N), .SEL_BITS(S)) dut (
    .clk(clk), .reset(reset), .mode(mode), .select(select),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_channel(out_channel),
    .out_valid(out_valid), .out_ready(out_ready),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  int           m_ch    = 0;
  int           m_lg    = N - 1;
  int           m_cnt   = 0;
  logic [N-1:0] last_ready;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_grant();
    if (!mode) begin
      if (int'(select) < N && in_valid[select]) return int'(select);
      return -1;
    end
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (m_lg + i) % N;
      if (in_valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic step();
    int           g;
    logic         can;
    logic [N-1:0] er;
    #2;
    g   = ref_grant();
    can = !m_valid || out_ready;
    er  = '0;
    if (!reset && g >= 0 && can) er = 16'(1) << g;
    last_ready = in_ready;
    chk("in_ready", in_ready, er);
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_ch = 0;
      m_lg = N - 1; m_cnt = 0;
    end else if (g >= 0 && can) begin
      m_valid = 1'b1;
      m_data  = in_data[g*W +: W];
      m_ch    = g;
      m_lg    = g;
      m_cnt   = (m_cnt + 1) % 65536;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_channel", out_channel, m_ch);
    chk("xfer_count", xfer_count, m_cnt);
  endtask

  task automatic set_idx_data();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(k);
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      chk("rst_ready", last_ready, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_count", xfer_count, 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] held_d;
    logic [15:0]  held_c;
    int           sp [3];
    sp[0] = 0; sp[1] = 1; sp[2] = 15;
    reset = 1'b1; mode = 1'b0; select = '0;
    in_data = '0; in_valid = '0; out_ready = 1'b1;
    do_reset(2);

    // fixed select
    mode = 1'b0; select = 4'd5; in_valid = 16'h0020;
    in_data = '0; in_data[5*W +: W] = 8'hA5;
    step();
    chk("fix_ready", last_ready, 32'h0020);
    chk("fix_data", out_data, 8'hA5);
    chk("fix_ch", out_channel, 5);
    chk("fix_valid", out_valid, 1);
    select = 4'd3;
    step();
    chk("fix_nogrant", last_ready, 0);
    chk("fix_drop", out_valid, 0);

    // round-robin fairness
    do_reset(1);
    mode = 1'b1; in_valid = 16'hFFFF; set_idx_data();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("rr_seq", out_channel, i % 16);
      chk("rr_data", out_data, i % 16);
      chk("rr_nobubble", out_valid, 1);
    end
    chk("rr_count", xfer_count, 20);

    // sparse with wrap
    do_reset(1);
    in_valid = 16'h8003;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("sparse_seq", out_channel, sp[i % 3]);
    end

    // backpressure
    in_valid = 16'hFFFF; out_ready = 1'b1;
    step();
    held_d = out_data; held_c = xfer_count;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_ready", last_ready, 0);
      chk("bp_data", out_data, held_d);
      chk("bp_count", xfer_count, held_c);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release", xfer_count, held_c + 16'd1);

    // reset mid-stream
    out_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("mid_valid", out_valid, 0);
    chk("mid_count", xfer_count, 0);
    reset = 1'b0; out_ready = 1'b1;
    step();
    chk("mid_first", out_channel, 0);

    // randomized
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(99) == 0);
      if ($urandom_range(19) == 0) mode = ~mode;
      select    = S'($urandom_range(N - 1));
      out_ready = ($urandom_range(3) != 0);
      case ($urandom_range(2))
        0: in_valid = N'($urandom);
        1: in_valid = N'($urandom) & N'($urandom) & N'($urandom);
        default: in_valid = 16'(1) << $urandom_range(N - 1);
      endcase
      for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
- Parametrised successor to the fixed 16:1 combinational select mux.
- Merges CHANNELS streaming input channels into one registered output stream, using valid/ready handshakes on both sides.
- Two channel-selection modes:
  - fixed: channel index comes from `select`;
  - round-robin: fair arbitration among the channels that are valid.
- Used between multiple producers (display/IO sources, CPU-side requesters) and a single consumer.

Parameters:
- WIDTH, 8: data width per channel.
- CHANNELS, 16: number of input channels; legal range 2..16.
- SEL_BITS, 4: width of the select and channel-index fields; 2^SEL_BITS >= CHANNELS required.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- select  input  SEL_BITS  channel index used in mode 0.
- in_data  input  CHANNELS*WIDTH  channel k occupies bits [(k+1)*WIDTH-1 : k*WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; at most one bit set (one-hot or zero).
- out_data  output  WIDTH  registered output word.
- out_channel  output  SEL_BITS  index of the channel that produced out_data.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the word.
- xfer_count  output  16  count of accepted input transfers; wraps 0xFFFF -> 0.

Behaviour:
- Reset (sampled on a clk edge with reset=1):
  - out_data=0, out_channel=0, out_valid=0, xfer_count=0.
  - Round-robin pointer last_grant=CHANNELS-1, so channel 0 has first priority.
  - in_ready is forced to all-zero while reset=1.
  - A word held at reset is discarded.
- Load condition: can_load = !out_valid || out_ready. This is a single output register with full throughput of one word per cycle.
- Grant, combinational from current inputs:
  - mode 0: grant = select when select < CHANNELS and in_valid[select]=1; otherwise no grant. An out-of-range select never grants and never indexes out of bounds.
  - mode 1: grant = first k with in_valid[k]=1, searching k = last_grant+1, last_grant+2, … with wrap at CHANNELS-1 -> 0. last_grant itself is searched last. No valid channel -> no grant.
- in_ready[grant] = can_load when a grant exists; all other bits 0. in_ready may depend combinationally on in_valid, mode, select and out_ready. in_valid must not depend on in_ready.
- Transfer occurs when a grant exists and can_load=1. On the next edge:
  - out_data <= in_data slice of the granted channel;
  - out_channel <= grant; out_valid <= 1;
  - last_grant <= grant, updated in both modes;
  - xfer_count <= xfer_count+1.
- No transfer but out_valid && out_ready: out_valid <= 0. out_data and out_channel hold their values.
- out_valid && !out_ready: the output register is frozen (backpressure) and no input is accepted.
- Latency: 1 cycle from an input transfer to out_valid.
- Simultaneous output accept and new input transfer in the same cycle: the new word replaces the old with no bubble.
- Mode or select changes take effect in the same cycle. Pointer state is kept across mode switches.
- Only the in_ready bit of the granted channel can be high, so a channel's data is never duplicated or dropped.

Test Plan (CHANNELS=16, WIDTH=8):
- Reset/idle: assert reset 2 cycles, all in_valid=0 -> out_valid=0, xfer_count=0, in_ready=0 for every cycle.
- Fixed select: mode=0, select=5, in_valid=16'h0020, ch5 data=8'hA5, out_ready=1 -> in_ready=16'h0020; the next cycle gives out_data=A5, out_channel=5, out_valid=1. Repeat with select=3 and ch3 invalid -> no grant, out_valid drops after accept.
- Round-robin fairness: mode=1, in_valid=16'hFFFF, channel k data=k, out_ready=1 for 20 cycles -> out_channel sequence 0,1,…,15,0,1,2,3 with no bubbles; xfer_count=20.
- Sparse round-robin with wrap: mode=1, in_valid=16'h8003 held -> order 0,1,15,0,1,15.
- Backpressure: word held, out_ready=0 for 4 cycles with inputs valid -> out_data stable, in_ready=0, xfer_count unchanged. Then out_ready=1 -> the next grant loads the same cycle.
- Reset mid-stream: out_valid=1 with out_ready=0, then assert reset -> the next cycle gives out_valid=0 and xfer_count=0, and the following round-robin grant starts at channel 0.
